// File: rtl/sha256_pkg.sv
// sha256_pkg
// Shared definitions for the SHA-256 round engine:
//   - block/state widths
//   - K[0..63] round-constant table and the standard initial hash value
//   - FSM state enum
//   - SIG0/SIG1 (compression), sig0/sig1 (schedule), Ch and Maj helpers
package sha256_pkg;

    localparam int BLOCK_W = 512;
    localparam int STATE_W = 256;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROUND,
        ST_DONE
    } sha_state_e;

    localparam logic [255:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] SIG0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] SIG1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] Ch(input logic [31:0] e, input logic [31:0] f,
                                       input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] Maj(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_round_engine_if.sv
// sha256_round_engine_if
// Bus between a requester (master) and the round engine (slave).
//   i_start          request to compress one block
//   i_block[511:0]   message block, W0 in the top word
//   i_hin[255:0]     chaining value H0..H7, H0 in the top word
//   o_busy           engine is loading or running rounds
//   o_count[6:0]     rounds completed
//   o_a .. o_h       working variables
//   o_done           single-cycle completion pulse
interface sha256_round_engine_if;
    import sha256_pkg::*;

    logic               i_start;
    logic [BLOCK_W-1:0] i_block;
    logic [STATE_W-1:0] i_hin;
    logic               o_busy;
    logic [6:0]         o_count;
    logic [31:0]        o_a, o_b, o_c, o_d, o_e, o_f, o_g, o_h;
    logic               o_done;

    modport slave (
        input  i_start, i_block, i_hin,
        output o_busy, o_count, o_a, o_b, o_c, o_d, o_e, o_f, o_g, o_h, o_done
    );

    modport master (
        output i_start, i_block, i_hin,
        input  o_busy, o_count, o_a, o_b, o_c, o_d, o_e, o_f, o_g, o_h, o_done
    );

endinterface

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched
// 16-word message schedule shift register. Entry 0 always holds W[t] for
// the current round; each advance shifts down by one and appends W[t+16].
//   i_clk, i_rst  clock, synchronous active-low reset
//   load          copy W0..W15 from block
//   advance       shift one word and append the next schedule word
//   block[511:0]  message block, W0 in the top word
//   w_t[31:0]     schedule word for the current round
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               load,
    input  logic               advance,
    input  logic [BLOCK_W-1:0] block,
    output logic [31:0]        w_t
);

    logic [31:0] w [16];
    logic [31:0] w_new;

    // With w[k] = W[t+k], the recurrence for W[t+16] uses entries 14, 9, 1 and 0.
    assign w_new = sig1(w[14]) + w[9] + sig0(w[1]) + w[0];
    assign w_t   = w[0];

    // Load has priority over advance; the FSM never asserts both together.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int i = 0; i < 16; i++) w[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < 16; i++) w[i] <= block[BLOCK_W-1-32*i -: 32];
        end else if (advance) begin
            for (int i = 0; i < 15; i++) w[i] <= w[i+1];
            w[15] <= w_new;
        end
    end

endmodule

// File: rtl/sha256_round_engine.sv
// sha256_round_engine
// Iterative SHA-256 compression: one round per clock, 65 cycles from an
// accepted start to completion (one LOAD cycle plus 64 ROUND cycles).
//   i_clk, i_rst  clock, synchronous active-low reset
//   bus           sha256_round_engine_if slave: i_start/i_block/i_hin in,
//                 o_busy/o_count/o_a..o_h/o_done out
//   DONE_HOLD     0: leave DONE after one cycle; 1: stay in DONE until i_start
module sha256_round_engine
    import sha256_pkg::*;
#(
    parameter bit DONE_HOLD = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    sha256_round_engine_if.slave  bus
);

    sha_state_e         state, state_next;
    logic               busy;
    logic               sched_load, sched_advance;
    logic [BLOCK_W-1:0] block_q;
    logic [STATE_W-1:0] hin_q;
    logic [31:0]        a, b, c, d, e, f, g, h;
    logic [6:0]         count;
    logic               done;
    logic [31:0]        w_t, t1, t2;

    sha256_msg_sched u_sched (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .load    (sched_load),
        .advance (sched_advance),
        .block   (block_q),
        .w_t     (w_t)
    );

    assign t1 = h + SIG1(e) + Ch(e, f, g) + K[count[5:0]] + w_t;
    assign t2 = SIG0(a) + Maj(a, b, c);

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state and control decode. A start during the first DONE cycle
    // (while o_done is pulsing) is deliberately dropped.
    always_comb begin
        state_next    = state;
        busy          = 1'b0;
        sched_load    = 1'b0;
        sched_advance = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.i_start) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                busy       = 1'b1;
                sched_load = 1'b1;
                state_next = ST_ROUND;
            end
            ST_ROUND: begin
                busy          = 1'b1;
                sched_advance = 1'b1;
                if (count == 7'd63) state_next = ST_DONE;
            end
            ST_DONE: begin
                if (!DONE_HOLD)                 state_next = ST_IDLE;
                else if (bus.i_start && !done)  state_next = ST_LOAD;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: capture inputs on an accepted start, seed a..h in LOAD,
    // run one compression round per ROUND cycle and flag the last one.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            block_q <= '0;
            hin_q   <= '0;
            {a, b, c, d, e, f, g, h} <= '0;
            count   <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state_next == ST_LOAD) begin
                block_q <= bus.i_block;
                hin_q   <= bus.i_hin;
                count   <= '0;
            end
            case (state)
                ST_LOAD: begin
                    {a, b, c, d, e, f, g, h} <= hin_q;
                    count <= '0;
                end
                ST_ROUND: begin
                    h     <= g;
                    g     <= f;
                    f     <= e;
                    e     <= d + t1;
                    d     <= c;
                    c     <= b;
                    b     <= a;
                    a     <= t1 + t2;
                    count <= count + 7'd1;
                    if (count == 7'd63) done <= 1'b1;
                end
                ST_DONE: begin
                    if (!DONE_HOLD) count <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_busy  = busy;
    assign bus.o_count = count;
    assign bus.o_done  = done;
    assign bus.o_a     = a;
    assign bus.o_b     = b;
    assign bus.o_c     = c;
    assign bus.o_d     = d;
    assign bus.o_e     = e;
    assign bus.o_f     = f;
    assign bus.o_g     = g;
    assign bus.o_h     = h;

endmodule

// File: tb/tb_sha256_round_engine.sv
// tb_sha256_round_engine
// Directed known-answer bench for sha256_round_engine. dut0 uses
// DONE_HOLD=0, dut1 uses DONE_HOLD=1; both share clock and reset.
module tb_sha256_round_engine;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   fails  = 0;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_448A  = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };
    localparam logic [511:0] BLK_448B  = {480'h0, 32'h000001c0};
    localparam logic [255:0] DIG_ABC   =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] DIG_EMPTY =
        256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] DIG_448   =
        256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    always #5 clk = ~clk;

    sha256_round_engine_if ifc0 ();
    sha256_round_engine_if ifc1 ();

    sha256_round_engine #(.DONE_HOLD(1'b0)) dut0 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (ifc0.slave)
    );

    sha256_round_engine #(.DONE_HOLD(1'b1)) dut1 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (ifc1.slave)
    );

    logic [255:0] st0, st1;
    assign st0 = {ifc0.o_a, ifc0.o_b, ifc0.o_c, ifc0.o_d, ifc0.o_e, ifc0.o_f, ifc0.o_g, ifc0.o_h};
    assign st1 = {ifc1.o_a, ifc1.o_b, ifc1.o_c, ifc1.o_d, ifc1.o_e, ifc1.o_f, ifc1.o_g, ifc1.o_h};

    // Word-wise modulo-2^32 addition of two 8-word states.
    function automatic logic [255:0] add_words(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
        return r;
    endfunction

    // Pulses start on dut0 and waits (bounded) for o_done; lat counts edges
    // after the accepting edge, busy_cycles counts samples with o_busy high.
    task automatic run0(input logic [511:0] blk, input logic [255:0] hin,
                        output int lat, output int busy_cycles);
        @(negedge clk);
        ifc0.i_block = blk;
        ifc0.i_hin   = hin;
        ifc0.i_start = 1'b1;
        @(negedge clk);
        ifc0.i_start = 1'b0;
        lat = 0;
        busy_cycles = 0;
        while (lat < 100) begin
            if (ifc0.o_busy === 1'b1) busy_cycles++;
            if (ifc0.o_done === 1'b1) break;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ifc0.o_busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy got %b want 0", ifc0.o_busy); end
        checks++; if (ifc0.o_count !== 7'd0) begin fails++; $display("[TB] FAIL reset_count got %0d want 0", ifc0.o_count); end
        checks++; if (ifc0.o_done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done got %b want 0", ifc0.o_done); end
        checks++; if (st0 !== 256'h0) begin fails++; $display("[TB] FAIL reset_state0 got %h want 0", st0); end
        checks++; if (st1 !== 256'h0) begin fails++; $display("[TB] FAIL reset_state1 got %h want 0", st1); end
        checks++; if (ifc1.o_count !== 7'd0) begin fails++; $display("[TB] FAIL reset_count1 got %0d want 0", ifc1.o_count); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_abc();
        int lat, bc;
        run0(BLK_ABC, IV, lat, bc);
        checks++; if (lat != 65) begin fails++; $display("[TB] FAIL abc_latency got %0d want 65", lat); end
        checks++; if (bc != 65) begin fails++; $display("[TB] FAIL abc_busy_cycles got %0d want 65", bc); end
        checks++; if (ifc0.o_count !== 7'd64) begin fails++; $display("[TB] FAIL abc_count got %0d want 64", ifc0.o_count); end
        checks++; if (ifc0.o_busy !== 1'b0) begin fails++; $display("[TB] FAIL abc_busy_done got %b want 0", ifc0.o_busy); end
        checks++; if (add_words(st0, IV) !== DIG_ABC) begin fails++; $display("[TB] FAIL abc_digest got %h want %h", add_words(st0, IV), DIG_ABC); end
        // start during the DONE cycle must be ignored
        ifc0.i_block = BLK_EMPTY;
        ifc0.i_start = 1'b1;
        @(negedge clk);
        ifc0.i_start = 1'b0;
        checks++; if (ifc0.o_count !== 7'd0) begin fails++; $display("[TB] FAIL after_done_count got %0d want 0", ifc0.o_count); end
        checks++; if (ifc0.o_done !== 1'b0) begin fails++; $display("[TB] FAIL after_done_pulse got %b want 0", ifc0.o_done); end
        checks++; if (ifc0.o_busy !== 1'b0) begin fails++; $display("[TB] FAIL done_start_ignored got %b want 0", ifc0.o_busy); end
        checks++; if (add_words(st0, IV) !== DIG_ABC) begin fails++; $display("[TB] FAIL abc_held got %h want %h", add_words(st0, IV), DIG_ABC); end
        @(negedge clk);
        checks++; if (ifc0.o_busy !== 1'b0) begin fails++; $display("[TB] FAIL idle_after_done got %b want 0", ifc0.o_busy); end
    endtask

    task automatic test_empty();
        int lat, bc;
        run0(BLK_EMPTY, IV, lat, bc);
        checks++; if (lat != 65) begin fails++; $display("[TB] FAIL empty_latency got %0d want 65", lat); end
        checks++; if (add_words(st0, IV) !== DIG_EMPTY) begin fails++; $display("[TB] FAIL empty_digest got %h want %h", add_words(st0, IV), DIG_EMPTY); end
    endtask

    task automatic test_two_block();
        int lat, bc;
        logic [255:0] h1;
        run0(BLK_448A, IV, lat, bc);
        checks++; if (lat != 65) begin fails++; $display("[TB] FAIL blk1_latency got %0d want 65", lat); end
        h1 = add_words(st0, IV);
        run0(BLK_448B, h1, lat, bc);
        checks++; if (lat != 65) begin fails++; $display("[TB] FAIL blk2_latency got %0d want 65", lat); end
        checks++; if (add_words(st0, h1) !== DIG_448) begin fails++; $display("[TB] FAIL two_block_digest got %h want %h", add_words(st0, h1), DIG_448); end
    endtask

    task automatic test_start_while_busy();
        int n;
        int pulses;
        logic [255:0] snap;
        @(negedge clk);
        ifc0.i_block = BLK_ABC;
        ifc0.i_hin   = IV;
        ifc0.i_start = 1'b1;
        @(negedge clk);
        ifc0.i_start = 1'b0;
        n = 0;
        while (ifc0.o_count !== 7'd10 && n < 100) begin @(negedge clk); n++; end
        checks++; if (n >= 100) begin fails++; $display("[TB] FAIL busy_reach_count10 got timeout want count 10"); end
        ifc0.i_block = BLK_EMPTY;
        ifc0.i_hin   = 256'h0;
        ifc0.i_start = 1'b1;
        @(negedge clk);
        ifc0.i_start = 1'b0;
        pulses = 0;
        snap   = 256'h0;
        for (int i = 0; i < 120; i++) begin
            if (ifc0.o_done === 1'b1) begin pulses++; snap = st0; end
            @(negedge clk);
        end
        checks++; if (pulses != 1) begin fails++; $display("[TB] FAIL busy_done_pulses got %0d want 1", pulses); end
        checks++; if (add_words(snap, IV) !== DIG_ABC) begin fails++; $display("[TB] FAIL busy_digest got %h want %h", add_words(snap, IV), DIG_ABC); end
        checks++; if (ifc0.o_busy !== 1'b0) begin fails++; $display("[TB] FAIL busy_no_queue got %b want 0", ifc0.o_busy); end
    endtask

    task automatic test_reset_mid();
        int n, lat, bc;
        logic seen;
        @(negedge clk);
        ifc0.i_block = BLK_ABC;
        ifc0.i_hin   = IV;
        ifc0.i_start = 1'b1;
        @(negedge clk);
        ifc0.i_start = 1'b0;
        n = 0;
        while (ifc0.o_count !== 7'd30 && n < 100) begin @(negedge clk); n++; end
        checks++; if (n >= 100) begin fails++; $display("[TB] FAIL mid_reach_count30 got timeout want count 30"); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ifc0.o_busy !== 1'b0) begin fails++; $display("[TB] FAIL mid_reset_busy got %b want 0", ifc0.o_busy); end
        checks++; if (ifc0.o_count !== 7'd0) begin fails++; $display("[TB] FAIL mid_reset_count got %0d want 0", ifc0.o_count); end
        checks++; if (st0 !== 256'h0) begin fails++; $display("[TB] FAIL mid_reset_state got %h want 0", st0); end
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (ifc0.o_done === 1'b1 || ifc0.o_count === 7'd64 || ifc0.o_busy === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen !== 1'b0) begin fails++; $display("[TB] FAIL mid_reset_aborted got activity %b want 0", seen); end
        run0(BLK_ABC, IV, lat, bc);
        checks++; if (lat != 65) begin fails++; $display("[TB] FAIL rerun_latency got %0d want 65", lat); end
        checks++; if (add_words(st0, IV) !== DIG_ABC) begin fails++; $display("[TB] FAIL rerun_digest got %h want %h", add_words(st0, IV), DIG_ABC); end
    endtask

    task automatic test_done_hold();
        int lat;
        int bad;
        @(negedge clk);
        ifc1.i_block = BLK_ABC;
        ifc1.i_hin   = IV;
        ifc1.i_start = 1'b1;
        @(negedge clk);
        ifc1.i_start = 1'b0;
        lat = 0;
        while (ifc1.o_done !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
        checks++; if (lat != 65) begin fails++; $display("[TB] FAIL hold_latency got %0d want 65", lat); end
        checks++; if (add_words(st1, IV) !== DIG_ABC) begin fails++; $display("[TB] FAIL hold_digest got %h want %h", add_words(st1, IV), DIG_ABC); end
        // start in the cycle DONE is entered must be ignored
        ifc1.i_block = BLK_EMPTY;
        ifc1.i_start = 1'b1;
        @(negedge clk);
        ifc1.i_start = 1'b0;
        checks++; if (ifc1.o_busy !== 1'b0) begin fails++; $display("[TB] FAIL hold_entry_start_ignored got %b want 0", ifc1.o_busy); end
        checks++; if (ifc1.o_count !== 7'd64) begin fails++; $display("[TB] FAIL hold_count got %0d want 64", ifc1.o_count); end
        checks++; if (ifc1.o_done !== 1'b0) begin fails++; $display("[TB] FAIL hold_pulse_width got %b want 0", ifc1.o_done); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ifc1.o_count !== 7'd64 || ifc1.o_busy !== 1'b0 || ifc1.o_done !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin fails++; $display("[TB] FAIL hold_20_cycles got %0d bad cycles want 0", bad); end
        checks++; if (add_words(st1, IV) !== DIG_ABC) begin fails++; $display("[TB] FAIL hold_state_kept got %h want %h", add_words(st1, IV), DIG_ABC); end
        ifc1.i_start = 1'b1;
        @(negedge clk);
        ifc1.i_start = 1'b0;
        checks++; if (ifc1.o_busy !== 1'b1) begin fails++; $display("[TB] FAIL hold_restart_busy got %b want 1", ifc1.o_busy); end
        checks++; if (ifc1.o_count !== 7'd0) begin fails++; $display("[TB] FAIL hold_restart_count got %0d want 0", ifc1.o_count); end
        lat = 0;
        while (ifc1.o_done !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
        checks++; if (lat != 65) begin fails++; $display("[TB] FAIL hold_restart_latency got %0d want 65", lat); end
        checks++; if (add_words(st1, IV) !== DIG_EMPTY) begin fails++; $display("[TB] FAIL hold_restart_digest got %h want %h", add_words(st1, IV), DIG_EMPTY); end
    endtask

    // Sequence the scenarios and print the summary.
    initial begin
        ifc0.i_start = 1'b0;
        ifc0.i_block = '0;
        ifc0.i_hin   = '0;
        ifc1.i_start = 1'b0;
        ifc1.i_block = '0;
        ifc1.i_hin   = '0;
        $display("[TB] starting sha256_round_engine bench");
        test_reset();
        test_abc();
        test_empty();
        test_two_block();
        test_start_while_busy();
        test_reset_mid();
        test_done_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/sha256_round_engine.md
SHA256_ROUND_ENGINE -- requirements
Module: sha256_round_engine

Interface
REQ-001 Parameter DONE_HOLD, default 0: 0 = o_count shows 64 for exactly one cycle, then returns to 0; 1 = o_count holds 64 until the next accepted i_start.
REQ-002 i_clk  input  1  clock; all state changes on the rising edge.
REQ-003 i_rst  input  1  reset, synchronous, active-low.
REQ-004 i_start  input  1  request to compress one block; sampled only in IDLE.
REQ-005 i_block  input  512  message block; word W0 = i_block[511:480], W15 = i_block[31:0].
REQ-006 i_hin  input  256  chaining value {H0..H7}, H0 in [255:224]; standard IV for the first block.
REQ-007 o_busy  output  1  high in LOAD and ROUND states.
REQ-008 o_count  output  7  rounds completed, 0..64.
REQ-009 o_a, o_b, o_c, o_d, o_e, o_f, o_g, o_h  output  32 each  working variables a..h.
REQ-010 o_done  output  1  one-cycle pulse on the cycle o_count first equals 64.

Function
REQ-011 FSM states: IDLE, LOAD, ROUND, DONE.
REQ-012 IDLE with i_start=1 -> LOAD; i_block and i_hin are captured on that edge.
REQ-013 LOAD (1 cycle): a..h <- H0..H7 from the captured i_hin; 16-word schedule buffer <- W0..W15; o_count <- 0; next state -> ROUND.
REQ-014 ROUND: one round per cycle, t = o_count = 0..63.
REQ-015 Round update: T1 = h + SIG1(e) + Ch(e,f,g) + K[t] + W[t]; T2 = SIG0(a) + Maj(a,b,c); h<-g, g<-f, f<-e, e<-d+T1, d<-c, c<-b, b<-a, a<-T1+T2.
REQ-016 Function definitions: SIG0 = ROTR2^ROTR13^ROTR22; SIG1 = ROTR6^ROTR11^ROTR25; Ch = (e&f)^(~e&g); Maj = (a&b)^(a&c)^(b&c).
REQ-017 Schedule: for t<16, W[t] is the loaded word; for t>=16, W[t] = sig1(W[t-2]) + W[t-7] + sig0(W[t-15]) + W[t-16], with sig0 = ROTR7^ROTR18^SHR3 and sig1 = ROTR17^ROTR19^SHR10.
REQ-018 The schedule is a 16-entry shift register: each round shifts it by one and appends the new word; there is no 64-word store.
REQ-019 All additions are modulo 2^32; carries out of bit 31 are discarded.
REQ-020 o_count increments once per ROUND cycle; after round 63, o_count = 64 and the state is DONE, with o_done=1 for that single cycle.
REQ-021 Latency: start accepted at edge N -> o_count=64 and o_done=1 after edge N+65.
REQ-022 DONE with DONE_HOLD=0: next cycle -> IDLE, o_count <- 0.
REQ-023 DONE with DONE_HOLD=1: stay in DONE until i_start=1, then go to LOAD.
REQ-024 o_a..o_h hold the final values in DONE and IDLE until the next LOAD.
REQ-025 i_start while o_busy=1 is ignored; no queuing, and the running computation is unaffected.
REQ-026 i_start in the same cycle DONE is entered is ignored.
REQ-027 o_a..o_h reflect the registered state after each round edge; there is no combinational path from i_block/i_hin to the outputs.

Reset
REQ-028 i_rst=0 at an edge: state <- IDLE; o_count, o_a..o_h and the schedule buffer <- 0; o_busy, o_done <- 0.
REQ-029 Reset applies in every state, including mid-ROUND; the aborted block produces no o_done and no o_count=64.
REQ-030 The first i_start after reset deasserts is accepted normally.

Structure
REQ-031 Shared package sha256_pkg holds: K[0..63] constant table, IV constants H0..H7, state enum, and functions SIG0, SIG1, sig0, sig1, Ch, Maj.
REQ-032 Sub-module sha256_msg_sched implements the 16-word W shift register and W[t] generation, with load and advance controls.
REQ-033 The round datapath and FSM reside in sha256_round_engine.

Verification
REQ-034 "abc" block (0x61626380, zeros, last word 0x00000018), i_hin=IV -> after 65 cycles o_done=1, o_count=64, and o_a+0x6a09e667 = 0xba7816bf (mod 2^32); all eight sums match ba7816bf...f20015ad.
REQ-035 Empty message (0x80000000, zeros), i_hin=IV -> final a..h plus IV = e3b0c442 98fc1c14 ... 7852b855.
REQ-036 448-bit "abcdbcdecdefghij..." as two blocks, second i_hin = first result plus IV -> final = 248d6a61 ... 19db06c1.
REQ-037 i_start pulsed at o_count=10 with a different block -> result identical to REQ-034 and exactly one o_done pulse.
REQ-038 i_rst=0 at o_count=30 -> next cycle IDLE, all outputs 0, no o_done; a fresh "abc" run then passes REQ-034.
REQ-039 DONE_HOLD=0: o_count=64 for exactly one cycle, then 0, with o_a..o_h held; DONE_HOLD=1: o_count=64 held for 20 cycles until i_start.
